// File: rtl/set_assoc_cache_pkg.sv
// Shared definitions for the set-associative cache: controller state
// encoding and the address-field width helpers.
package set_assoc_cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } cache_state_t;

    // Word-offset bits within a line.
    function automatic int ofs_bits(input int words);
        return $clog2(words);
    endfunction

    // Set-index bits.
    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Tag bits: 30 word-address bits minus index and offset.
    function automatic int tag_bits(input int sets, input int words);
        return 30 - $clog2(sets) - $clog2(words);
    endfunction

    // Way-select width, kept at least one bit so a direct-mapped
    // build still has a legal vector.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// Memory-side bus of the cache.
// Handshake: the cache holds mem_req, mem_we, mem_addr and mem_wdata stable
// while mem_req=1; a beat transfers on every rising edge where
// mem_req=1 and mem_ready=1 (mem_rdata is sampled on that edge for reads).
// mem_ready while mem_req=0 has no effect.
interface set_assoc_cache_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/set_assoc_cache_way_ram.sv
// One way of the cache: tag, valid, dirty and line data for every set.
// Asynchronous read port, single synchronous write port. Only the valid
// and dirty bits are reset; tag and data contents are don't-care until
// a line is marked valid.
module cache_way_ram #(
    parameter int SETS  = 64,
    parameter int WORDS = 8,
    parameter int IDX   = 6,
    parameter int OFS   = 3,
    parameter int TAG   = 21
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [IDX-1:0] rd_idx,
    input  logic [OFS-1:0] rd_word,
    output logic           rd_valid,
    output logic           rd_dirty,
    output logic [TAG-1:0] rd_tag,
    output logic [31:0]    rd_data,
    input  logic           data_we,
    input  logic [IDX-1:0] wr_idx,
    input  logic [OFS-1:0] wr_word,
    input  logic [31:0]    wr_data,
    input  logic           meta_we,
    input  logic           meta_dirty,
    input  logic [TAG-1:0] meta_tag
);
    logic [SETS-1:0] valid_bits;
    logic [SETS-1:0] dirty_bits;
    logic [TAG-1:0]  tag_mem  [SETS];
    logic [31:0]     data_mem [SETS][WORDS];

    assign rd_valid = valid_bits[rd_idx];
    assign rd_dirty = dirty_bits[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx][rd_word];

    // A metadata write always makes the line valid; only reset invalidates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (meta_we) begin
            valid_bits[wr_idx] <= 1'b1;
            dirty_bits[wr_idx] <= meta_dirty;
        end
    end

    // Tag and data storage, no reset.
    always_ff @(posedge clk) begin
        if (meta_we) tag_mem[wr_idx] <= meta_tag;
        if (data_we) data_mem[wr_idx][wr_word] <= wr_data;
    end

endmodule

// File: rtl/set_assoc_cache.sv
// Write-back, write-allocate set-associative cache controller. Hits
// complete one cycle after acceptance; misses optionally write back the
// dirty victim, fill the line beat by beat, then respond from RESP.
module set_assoc_cache
    import set_assoc_cache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int WAYS  = 2,
    parameter int WORDS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    set_assoc_cache_if.master mem,
    output cache_state_t      fsm_state
);
    localparam int OFS = ofs_bits(WORDS);
    localparam int IDX = idx_bits(SETS);
    localparam int TAG = tag_bits(SETS, WORDS);
    localparam int WW  = way_bits(WAYS);
    localparam logic [OFS-1:0] LAST_BEAT = OFS'(WORDS - 1);

    cache_state_t   state, state_next;
    logic [OFS-1:0] beat;
    logic [29:0]    req_waddr;
    logic           req_we;
    logic [31:0]    req_wdata;
    logic [WW-1:0]  victim, victim_sel, hit_way, wr_way;
    logic [WW-1:0]  rr_ptr [SETS];

    logic [TAG-1:0] cpu_tag, req_tag, meta_tag;
    logic [IDX-1:0] cpu_idx, req_idx, rd_idx, wr_idx;
    logic [OFS-1:0] cpu_ofs, req_ofs, rd_word, wr_word;
    logic [WAYS-1:0] way_valid, way_dirty, hit_vec;
    logic [TAG-1:0] way_tag  [WAYS];
    logic [31:0]    way_data [WAYS];
    logic [31:0]    wr_data;
    logic hit, victim_dirty, accept, beat_adv, data_we, meta_we, meta_dirty;
    logic byte_lane_unused;

    assign byte_lane_unused = ^cpu_addr[1:0];

    assign cpu_tag = cpu_addr[31 -: TAG];
    assign cpu_idx = cpu_addr[OFS+2 +: IDX];
    assign cpu_ofs = cpu_addr[2 +: OFS];
    assign req_tag = req_waddr[29 -: TAG];
    assign req_idx = req_waddr[OFS +: IDX];
    assign req_ofs = req_waddr[OFS-1:0];

    // While idle the read port looks up the incoming request; afterwards
    // it follows the latched request (write-back walks the beats).
    assign rd_idx  = (state == IDLE) ? cpu_idx : req_idx;
    assign rd_word = (state == IDLE) ? cpu_ofs : ((state == WB) ? beat : req_ofs);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way_ram #(
            .SETS(SETS), .WORDS(WORDS), .IDX(IDX), .OFS(OFS), .TAG(TAG)
        ) u_ram (
            .clk        (clk),
            .reset      (reset),
            .rd_idx     (rd_idx),
            .rd_word    (rd_word),
            .rd_valid   (way_valid[w]),
            .rd_dirty   (way_dirty[w]),
            .rd_tag     (way_tag[w]),
            .rd_data    (way_data[w]),
            .data_we    (data_we && (wr_way == WW'(w))),
            .wr_idx     (wr_idx),
            .wr_word    (wr_word),
            .wr_data    (wr_data),
            .meta_we    (meta_we && (wr_way == WW'(w))),
            .meta_dirty (meta_dirty),
            .meta_tag   (meta_tag)
        );
        assign hit_vec[w] = way_valid[w] && (way_tag[w] == cpu_tag);
    end

    assign hit          = $onehot(hit_vec);
    assign accept       = (state == IDLE) && cpu_req;
    assign beat_adv     = mem.mem_req && mem.mem_ready;
    assign victim_dirty = way_valid[victim_sel] && way_dirty[victim_sel];
    assign cpu_stall    = (state != IDLE);
    assign fsm_state    = state;
    assign mem.mem_req  = (state == WB) || (state == FILL);
    assign mem.mem_we   = (state == WB);

    // Encode the matching way.
    always_comb begin
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_way = WW'(w);
        end
    end

    // Victim: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        victim_sel = rr_ptr[cpu_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) victim_sel = WW'(w);
        end
    end

    // Memory bus address/data for the current beat.
    always_comb begin
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (state == WB) begin
            mem.mem_addr  = {way_tag[victim], req_idx, beat, 2'b00};
            mem.mem_wdata = way_data[victim];
        end else if (state == FILL) begin
            mem.mem_addr  = {req_tag, req_idx, beat, 2'b00};
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cpu_req && !hit) state_next = victim_dirty ? WB : FILL;
            WB:   if (beat_adv && (beat == LAST_BEAT)) state_next = FILL;
            FILL: if (beat_adv && (beat == LAST_BEAT)) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Way-RAM write control: write hit, fill beats, and the RESP
    // metadata update that also merges a write-miss word.
    always_comb begin
        data_we    = 1'b0;
        meta_we    = 1'b0;
        wr_way     = victim;
        wr_idx     = req_idx;
        wr_word    = req_ofs;
        wr_data    = req_wdata;
        meta_dirty = 1'b0;
        meta_tag   = req_tag;
        case (state)
            IDLE: if (cpu_req && hit && cpu_we) begin
                data_we    = 1'b1;
                meta_we    = 1'b1;
                wr_way     = hit_way;
                wr_idx     = cpu_idx;
                wr_word    = cpu_ofs;
                wr_data    = cpu_wdata;
                meta_dirty = 1'b1;
                meta_tag   = cpu_tag;
            end
            FILL: if (mem.mem_ready) begin
                data_we = 1'b1;
                wr_word = beat;
                wr_data = mem.mem_rdata;
            end
            RESP: begin
                meta_we    = 1'b1;
                meta_dirty = req_we;
                data_we    = req_we;
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Beat counter, advances only on accepted memory beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        beat <= '0;
        else if (beat_adv) beat <= beat + 1'b1;
    end

    // Latch the request and chosen victim at acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_waddr <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            victim    <= '0;
        end else if (accept) begin
            req_waddr <= cpu_addr[31:2];
            req_we    <= cpu_we;
            req_wdata <= cpu_wdata;
            victim    <= victim_sel;
        end
    end

    // Round-robin pointer per set, advanced on each completed fill.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else if (state == RESP) begin
            rr_ptr[req_idx] <= (rr_ptr[req_idx] == WW'(WAYS - 1)) ? '0 : rr_ptr[req_idx] + 1'b1;
        end
    end

    // CPU response: done pulse and read data, held between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_done  <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            cpu_done <= (accept && hit) || (state == RESP);
            if (accept && hit && !cpu_we)          cpu_rdata <= way_data[hit_way];
            else if ((state == RESP) && !req_we)   cpu_rdata <= way_data[victim];
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: directed cold/hit/eviction/reset scenarios
// followed by randomized traffic, checked against a transaction-level
// cache model and a memory responder that checks every bus beat.
module tb_set_assoc_cache;
    import set_assoc_cache_pkg::*;

    localparam int SETS  = 64;
    localparam int WAYS  = 2;
    localparam int WORDS = 8;

    logic         clk;
    logic         reset;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_done;
    logic         cpu_stall;
    cache_state_t fsm_state;

    set_assoc_cache_if mem_bus ();

    set_assoc_cache #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_done  (cpu_done),
        .cpu_stall (cpu_stall),
        .mem       (mem_bus.master),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];   // expected cpu_rdata per completion
    logic [64:0] beat_q[$];  // expected {we, addr, wdata} per memory beat
    int checks   = 0;
    int failures = 0;
    int ready_pct = 100;
    logic [31:0] backing [int unsigned];

    function automatic void check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS][WORDS];
    int          m_rr    [SETS];
    logic [31:0] m_mem   [int unsigned];
    logic [31:0] m_last_rdata;

    function automatic logic [31:0] init_word(input int unsigned waddr);
        return 32'hA000_0000 + waddr;
    endfunction

    function automatic logic [31:0] model_word(input int unsigned waddr);
        return m_mem.exists(waddr) ? m_mem[waddr] : init_word(waddr);
    endfunction

    function automatic logic [31:0] backing_word(input int unsigned waddr);
        return backing.exists(waddr) ? backing[waddr] : init_word(waddr);
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
        m_last_rdata = 32'h0;
    endfunction

    // One CPU access: updates the model and queues the expected memory
    // beats and completion data.
    function automatic void model_access(input bit we, input logic [31:0] addr,
                                         input logic [31:0] wdata, output bit hit);
        int unsigned waddr = addr >> 2;
        int unsigned ofs   = waddr % WORDS;
        int unsigned idx   = (waddr / WORDS) % SETS;
        int unsigned tag   = waddr / (WORDS * SETS);
        int          way   = -1;
        int unsigned base;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[idx][w] && m_tag[idx][w] == tag) way = w;
        hit = (way >= 0);
        if (!hit) begin
            for (int w = WAYS - 1; w >= 0; w--)
                if (!m_valid[idx][w]) way = w;
            if (way < 0) way = m_rr[idx];
            if (m_valid[idx][way] && m_dirty[idx][way]) begin
                base = (m_tag[idx][way] * SETS + idx) * WORDS;
                for (int b = 0; b < WORDS; b++) begin
                    beat_q.push_back({1'b1, 32'((base + b) * 4), m_data[idx][way][b]});
                    m_mem[base + b] = m_data[idx][way][b];
                end
            end
            base = (tag * SETS + idx) * WORDS;
            for (int b = 0; b < WORDS; b++) begin
                beat_q.push_back({1'b0, 32'((base + b) * 4), 32'h0});
                m_data[idx][way][b] = model_word(base + b);
            end
            m_valid[idx][way] = 1'b1;
            m_dirty[idx][way] = 1'b0;
            m_tag[idx][way]   = tag;
            m_rr[idx]         = (m_rr[idx] + 1) % WAYS;
        end
        if (we) begin
            m_data[idx][way][ofs] = wdata;
            m_dirty[idx][way]     = 1'b1;
        end else begin
            m_last_rdata = m_data[idx][way][ofs];
        end
        exp_q.push_back(m_last_rdata);
    endfunction

    // ---------------- memory responder (checks each beat) ----------------
    initial begin
        logic [64:0] b;
        logic [64:0] act;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_bus.mem_ready = 1'b0;
            mem_bus.mem_rdata = $urandom;
            if (mem_bus.mem_req !== 1'b1) begin
                mem_bus.mem_ready = 1'($urandom_range(1));
            end else if (beat_q.size() == 0) begin
                check("mem_req_unexpected", 65'(mem_bus.mem_req), 65'h0);
            end else if ($urandom_range(99) < ready_pct) begin
                b   = beat_q.pop_front();
                act = {mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_we ? mem_bus.mem_wdata : 32'h0};
                check("mem_beat", act, b);
                mem_bus.mem_ready = 1'b1;
                if (mem_bus.mem_we) backing[mem_bus.mem_addr >> 2] = mem_bus.mem_wdata;
                else                mem_bus.mem_rdata = backing_word(mem_bus.mem_addr >> 2);
            end
        end
    end

    // ---------------- completion monitor ----------------
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (cpu_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 65'(cpu_done), 65'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("cpu_rdata", 65'(cpu_rdata), 65'(e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_outputs_zero(input string tag);
        check({tag, "_cpu_rdata"}, 65'(cpu_rdata), 65'h0);
        check({tag, "_cpu_done"},  65'(cpu_done),  65'h0);
        check({tag, "_cpu_stall"}, 65'(cpu_stall), 65'h0);
        check({tag, "_mem_req"},   65'(mem_bus.mem_req),   65'h0);
        check({tag, "_mem_we"},    65'(mem_bus.mem_we),    65'h0);
        check({tag, "_mem_addr"},  65'(mem_bus.mem_addr),  65'h0);
        check({tag, "_mem_wdata"}, 65'(mem_bus.mem_wdata), 65'h0);
        check({tag, "_fsm_state"}, 65'(fsm_state), 65'(IDLE));
    endtask

    task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        bit hit;
        bit done;
        int cyc;
        int stall_low;
        model_access(we, addr, wdata, hit);
        @(negedge clk);
        check("stall_before_accept", 65'(cpu_stall), 65'h0);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(posedge clk);
        #1;
        cpu_req   = 1'b0;
        cpu_we    = 1'($urandom_range(1));
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        cyc = 0;
        done = 1'b0;
        stall_low = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cpu_done === 1'b1) done = 1'b1;
            else if (cpu_stall !== 1'b1) stall_low++;
        end
        check("done_timeout", 65'(done), 65'h1);
        check("stall_at_done", 65'(cpu_stall), 65'h0);
        if (hit) begin
            check("hit_latency", 65'(cyc), 65'h1);
        end else begin
            check("miss_stall_held", 65'(stall_low), 65'h0);
            check("miss_beats_consumed", 65'(beat_q.size()), 65'h0);
        end
        @(negedge clk);
        check("done_single_pulse", 65'(cpu_done), 65'h0);
    endtask

    // Abandon a fill at beat 3 with an asynchronous reset.
    task automatic reset_mid_fill();
        ready_pct = 100;
        @(negedge clk);
        for (int b = 0; b < 3; b++) beat_q.push_back({1'b0, 32'h0000_3000 + 32'(b * 4), 32'h0});
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_3000;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("fill_beat3_addr", 65'(mem_bus.mem_addr), 65'h300C);
        reset = 1'b0;
        #1;
        check_outputs_zero("midfill_reset");
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("midfill_beats_left", 65'(beat_q.size()), 65'h0);
        do_access(1'b0, 32'h0000_3000, 32'h0);
        do_access(1'b0, 32'h0000_301C, 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int sets_sel [4];
        logic [31:0] a;
        sets_sel = '{0, 1, 8, 63};
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        reset     = 1'b1;
        model_reset();
        #1 reset = 1'b0;
        #3;
        check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // cold read, then hit in the same line
        do_access(1'b0, 32'h0000_0100, 32'h0);
        do_access(1'b0, 32'h0000_0104, 32'h0);
        // write hit, fill second way, evict the dirty first way
        do_access(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        do_access(1'b0, 32'h0000_0900, 32'h0);
        do_access(1'b0, 32'h0000_1100, 32'h0);
        // re-read the written-back word through a fresh fill
        do_access(1'b0, 32'h0000_0100, 32'h0);
        // slow memory during fill
        ready_pct = 30;
        do_access(1'b0, 32'h0000_0208, 32'h0);
        do_access(1'b1, 32'h0000_0214, 32'h1234_5678);
        ready_pct = 100;

        reset_mid_fill();

        for (int i = 0; i < 300; i++) begin
            ready_pct = $urandom_range(100, 20);
            a = (32'($urandom_range(5)) << 11) | (32'(sets_sel[$urandom_range(3)]) << 5)
              | (32'($urandom_range(WORDS - 1)) << 2) | 32'($urandom_range(3));
            do_access(1'($urandom_range(1)), a, $urandom);
        end

        repeat (5) @(negedge clk);
        check("exp_q_drained",  65'(exp_q.size()),  65'h0);
        check("beat_q_drained", 65'(beat_q.size()), 65'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
